// File: rtl/ysyx_22050612_regfile_mp.sv
// Multi-port register file: combinational reads, two prioritised write ports and a
// post-reset sweep that zeroes every entry before normal writes are accepted.
// state | meaning
// CLEAR | sweep zeroing rf[cnt] each cycle, writes dropped, reads return 0
// READY | normal operation, writes and bypassed reads enabled
module ysyx_22050612_regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_READ    = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             wen1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
  output logic                             init_busy,
  output logic                             wr_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    wr_drop_q, wr_drop_d;
  logic [DATA_WIDTH-1:0]   rf_q [DEPTH];
  logic                    we0, we1, active;

  // Reads and writes are both gated off in the reset cycle itself.
  assign active = rst_n && (state_q == READY);
  assign we0    = active && wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign we1    = active && wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    if (state_q == CLEAR) begin
      cnt_d     = cnt_q + ADDR_WIDTH'(1);
      wr_drop_d = wen0 | wen1;
      if (cnt_q == LAST) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == CLEAR)) rf_q[cnt_q] <= '0;
    if (we0) rf_q[waddr0] <= wdata0;
    if (we1) rf_q[waddr1] <= wdata1;
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = '0;
      if (active && !((ZERO_REG != 0) && (ra == '0))) begin
        rd = rf_q[ra];
        if (BYPASS != 0) begin
          if (wen1 && (waddr1 == ra))      rd = wdata1;
          else if (wen0 && (waddr0 == ra)) rd = wdata0;
        end
      end
    end

    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

  assign init_busy = (state_q == CLEAR);
  assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_ysyx_22050612_regfile_mp.sv
// Randomised and directed bench for the multi-port register file, checked against
// an array-based model of the register contents and sweep.
module tb_ysyx_22050612_regfile_mp;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic wen0, wen1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic init_busy, wr_drop;

  ysyx_22050612_regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .init_busy(init_busy), .wr_drop(wr_drop)
  );

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  // Reference model: contents array plus "sweep remaining" bookkeeping.
  logic [DW-1:0] m_mem [DEPTH];
  bit m_busy  = 1'b1;
  int m_cnt   = 0;
  bit m_drop  = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b1; m_cnt = 0; m_drop = 1'b0; m_valid = 1'b1;
    end else if (m_busy) begin
      m_mem[m_cnt] = '0;
      m_drop = wen0 | wen1;
      if (m_cnt == DEPTH - 1) m_busy = 1'b0;
      m_cnt = m_cnt + 1;
    end else begin
      m_drop = 1'b0;
      if (wen0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (wen1 && waddr1 != 0) m_mem[waddr1] = wdata1;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (!rst_n || m_busy || a == 0) return '0;
    if (wen1 && waddr1 == a) return wdata1;
    if (wen0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("init_busy", {63'd0, init_busy}, {63'd0, m_busy});
      chk("wr_drop", {63'd0, wr_drop}, {63'd0, m_drop});
      for (int p = 0; p < NR; p++)
        chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], m_read(raddr[p*AW +: AW]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  // Counts busy cycles over a bounded window while the sweep runs.
  task automatic count_busy(input bool_unused);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy) busy_cnt++;
      step();
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(2, AW'(i));
      @(negedge clk);
      chk(name, rdata[2*DW +: DW], '0);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First sweep, with a write attempted in the 4th sweep cycle.
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      wen0 = (i == 3); waddr0 = 5'd9; wdata0 = 64'h55;
      @(negedge clk);
      if (init_busy) busy_cnt++;
      if (i == 4) chk("drop_in_sweep", {63'd0, wr_drop}, 64'd1);
      step();
    end
    idle();
    chk("busy_len_first", 64'(busy_cnt), 64'd32);
    set_rd(0, 5'd9);
    @(negedge clk);
    chk("lost_write", rdata[0 +: DW], '0);
    step();
    check_all_zero("sweep1_zero");

    // Write then read back, with same-cycle bypass on port 1.
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hDEAD; set_rd(1, 5'd5);
    @(negedge clk);
    chk("bypass_dead", rdata[1*DW +: DW], 64'hDEAD);
    step();
    idle(); set_rd(0, 5'd5);
    @(negedge clk);
    chk("read_dead", rdata[0 +: DW], 64'hDEAD);
    chk("no_drop_ready", {63'd0, wr_drop}, 64'd0);
    step();

    // Same-address collision and zero register.
    wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
    wdata0 = 64'h11; wdata1 = 64'h22;
    step();
    idle(); set_rd(0, 5'd7);
    @(negedge clk);
    chk("prio_port1", rdata[0 +: DW], 64'h22);
    step();
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 64'hFFFF; set_rd(0, 5'd0);
    @(negedge clk);
    chk("x0_bypass", rdata[0 +: DW], '0);
    step();
    idle();
    @(negedge clk);
    chk("x0_after", rdata[0 +: DW], '0);
    step();

    // Three ports reading overlapping addresses.
    wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 64'hA;
    wen1 = 1'b1; waddr1 = 5'd31; wdata1 = 64'hB;
    step();
    idle(); set_rd(0, 5'd1); set_rd(1, 5'd1); set_rd(2, 5'd31);
    @(negedge clk);
    chk("mp_r0", rdata[0 +: DW], 64'hA);
    chk("mp_r1", rdata[1*DW +: DW], 64'hA);
    chk("mp_r2", rdata[2*DW +: DW], 64'hB);
    step();

    // Random traffic, addresses biased to a small window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      wen0 = 1'($urandom); wen1 = 1'($urandom);
      waddr0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      waddr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wdata0 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
      for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 8)));
      step();
    end
    idle();

    // Fill, reset, interrupt the sweep with a second reset.
    for (int i = 1; i < DEPTH; i++) begin
      wen0 = 1'b1; waddr0 = AW'(i); wdata0 = 64'(i);
      step();
    end
    idle(); set_rd(0, 5'd20);
    @(negedge clk);
    chk("fill_r20", rdata[0 +: DW], 64'd20);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wen1 = 1'($urandom); waddr1 = AW'($urandom); wdata1 = {$urandom, $urandom};
      step();
    end
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy(1'b0);
    chk("busy_len_restart", 64'(busy_cnt), 64'd32);
    check_all_zero("sweep2_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  typedef bit bool_unused_t;
endmodule
